// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus downstream valid/ready stream, bundled for the burst reader.
interface fifo_burst_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        input  fifo_empty, fifo_dout, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_dout, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Pops a programmed burst from a show-ahead FIFO onto a registered valid/ready stream.
// Latency: first beat valid 2 cycles after start; 1 beat/cycle; pops stall while the output slot is held.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 256,
    parameter int LEN_WIDTH  = $clog2(MAX_BURST + 1),
    parameter int TIMEOUT    = 64,
    parameter int TO_WIDTH   = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] burst_len,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [LEN_WIDTH-1:0] beats_sent,
    fifo_burst_reader_if.master  bus
);

    // A zero TIMEOUT still needs a one-bit counter to keep the declarations legal.
    localparam int SW = (TO_WIDTH < 1) ? 1 : TO_WIDTH;
    localparam logic [SW-1:0]        STALL_MAX = SW'(TIMEOUT);
    localparam logic [LEN_WIDTH-1:0] MAX_LEN   = LEN_WIDTH'(MAX_BURST);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t               state, state_nxt;
    logic [LEN_WIDTH-1:0] remaining;
    logic [LEN_WIDTH-1:0] start_len;
    logic [SW-1:0]        stall_cnt;
    logic                 slot_free;
    logic                 pop;
    logic                 start_acc;
    logic                 timed_out;

    assign slot_free = !bus.m_valid || bus.m_ready;
    assign start_len = (burst_len > MAX_LEN) ? MAX_LEN : burst_len;
    assign start_acc = (state == S_IDLE) && start;
    assign timed_out = (TIMEOUT != 0) && (stall_cnt == STALL_MAX);

    assign busy           = (state != S_IDLE);
    assign done           = (state == S_DONE);
    assign bus.fifo_rd_en = pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (start_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                pop = (remaining != '0) && !bus.fifo_empty && slot_free;
                if (pop && remaining == LEN_WIDTH'(1)) begin
                    state_nxt = S_FLUSH;
                end else if (timed_out) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (slot_free) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Burst bookkeeping: remaining beats, stall timer, error flag, accepted-beat count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining  <= '0;
            stall_cnt  <= '0;
            err        <= 1'b0;
            beats_sent <= '0;
        end else if (start_acc) begin
            remaining  <= start_len;
            stall_cnt  <= '0;
            err        <= 1'b0;
            beats_sent <= '0;
        end else begin
            if (pop) begin
                remaining <= remaining - LEN_WIDTH'(1);
                stall_cnt <= '0;
            end else if (state == S_RUN && bus.fifo_empty && (TIMEOUT != 0) && !timed_out) begin
                stall_cnt <= stall_cnt + SW'(1);
            end
            if (state == S_RUN && timed_out) begin
                err <= 1'b1;
            end
            if (bus.m_valid && bus.m_ready) begin
                beats_sent <= beats_sent + LEN_WIDTH'(1);
            end
        end
    end

    // Output register: loads on a pop, drains when accepted, holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            bus.m_last  <= 1'b0;
        end else if (pop) begin
            bus.m_valid <= 1'b1;
            bus.m_data  <= bus.fifo_dout;
            bus.m_last  <= (remaining == LEN_WIDTH'(1));
        end else if (bus.m_ready) begin
            bus.m_valid <= 1'b0;
            bus.m_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue-backed FIFO model, stream scoreboard, vector table and random bursts.
module tb_fifo_burst_reader;

    localparam int DW   = 8;
    localparam int MAXB = 256;
    localparam int LW   = 9;
    localparam int TO   = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] burst_len = '0;
    logic          busy, done, err;
    logic [LW-1:0] beats_sent;

    fifo_burst_reader_if #(.DATA_WIDTH(DW)) bus();

    fifo_burst_reader #(
        .DATA_WIDTH(DW), .MAX_BURST(MAXB), .LEN_WIDTH(LW), .TIMEOUT(TO), .TO_WIDTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .burst_len(burst_len),
        .busy(busy), .done(done), .err(err), .beats_sent(beats_sent), .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Show-ahead FIFO model: circular storage with free-running pointers.
    logic [DW-1:0] mem [0:1023];
    logic [31:0]   rd_ptr = 0;
    logic [31:0]   wr_ptr = 0;

    assign bus.fifo_empty = (rd_ptr == wr_ptr);
    assign bus.fifo_dout  = mem[rd_ptr[9:0]];

    always @(posedge clk) begin
        if (bus.fifo_rd_en) rd_ptr <= rd_ptr + 1;
    end

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0d, required %0d", name, act, req);
        end
    endtask

    // Downstream ready patterns: 0 always ready, 1 alternating, 2 random.
    int ready_mode = 0;
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.m_ready = 1'b1;
                1:       bus.m_ready = ~bus.m_ready;
                default: bus.m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Stream monitor: collects accepted beats and flags protocol violations.
    logic [DW:0]   got_q[$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (bus.fifo_rd_en && bus.fifo_empty) begin
                fails++;
                $display("FAIL pop_when_empty at %0t: actual rd_en=1, required 0", $time);
            end
            if (bus.fifo_rd_en && bus.m_valid && !bus.m_ready) begin
                fails++;
                $display("FAIL pop_without_slot at %0t: actual rd_en=1, required 0", $time);
            end
            if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data || bus.m_last !== prev_last)) begin
                fails++;
                $display("FAIL hold_stable at %0t: actual v=%0d d=%0h l=%0d, required v=1 d=%0h l=%0d",
                         $time, bus.m_valid, bus.m_data, bus.m_last, prev_data, prev_last);
            end
            if (bus.m_valid && bus.m_ready) got_q.push_back({bus.m_last, bus.m_data});
            prev_stall <= bus.m_valid && !bus.m_ready;
            prev_data  <= bus.m_data;
            prev_last  <= bus.m_last;
        end
    end

    task automatic flush_fifo();
        wr_ptr = rd_ptr;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        mem[wr_ptr[9:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    // Reference: a burst delivers min(len, MAX_BURST) words unless the FIFO runs dry first.
    function automatic int model_beats(input int len, input int avail);
        int eff;
        eff = (len > MAXB) ? MAXB : len;
        return (avail < eff) ? avail : eff;
    endfunction

    function automatic bit model_err(input int len, input int avail);
        int eff;
        eff = (len > MAXB) ? MAXB : len;
        return avail < eff;
    endfunction

    task automatic run_burst(input int len, input int avail, input int mode, input int exp_beats,
                             input bit exp_err, input bit mid_start, input string tag);
        logic [DW-1:0] base;
        logic [DW-1:0] e;
        bit            seen;
        int            n;
        flush_fifo();
        base = DW'($urandom);
        for (int i = 0; i < avail; i++) push_word(base + DW'(i));
        ready_mode = mode;
        got_q.delete();
        @(posedge clk); #1;
        start = 1'b1;
        burst_len = LW'(len);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check({tag, " err_clear_on_start"}, err, 0);
        seen = 0;
        for (int c = 0; c < 4 * len + 100 && !seen; c++) begin
            if (c > 0) @(negedge clk);
            if (done) seen = 1;
            else if (mid_start && c == 40) begin
                start = 1'b1;
                burst_len = LW'(3);
            end else start = 1'b0;
        end
        start = 1'b0;
        check({tag, " done_seen"}, seen, 1);
        check({tag, " beats_sent"}, beats_sent, exp_beats);
        check({tag, " err"}, err, exp_err);
        @(negedge clk);
        check({tag, " busy_after"}, busy, 0);
        check({tag, " done_one_cycle"}, done, 0);
        check({tag, " beat_count"}, got_q.size(), exp_beats);
        n = (got_q.size() < exp_beats) ? got_q.size() : exp_beats;
        for (int i = 0; i < n; i++) begin
            e = base + DW'(i);
            check({tag, " data"}, got_q[i][DW-1:0], e);
            check({tag, " last"}, got_q[i][DW], (i == exp_beats - 1) && !exp_err);
        end
    endtask

    typedef struct {
        int len;
        int avail;
        int mode;
        int exp_beats;
        bit exp_err;
        bit mid_start;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset err", err, 0);
        check("reset rd_en", bus.fifo_rd_en, 0);
        check("reset m_valid", bus.m_valid, 0);
        check("reset m_last", bus.m_last, 0);
        check("reset m_data", bus.m_data, 0);
        check("reset beats_sent", beats_sent, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Exact-timing normal burst: start high during cycle T.
        flush_fifo();
        for (int i = 0; i < 4; i++) push_word(8'h10 + DW'(i));
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        burst_len = LW'(4);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("t1 rd_en T+%0d", k), bus.fifo_rd_en, (k >= 1 && k <= 4));
            check($sformatf("t1 m_valid T+%0d", k), bus.m_valid, (k >= 2 && k <= 5));
            if (k >= 2 && k <= 5) begin
                check($sformatf("t1 m_data T+%0d", k), bus.m_data, 8'h10 + k - 2);
                check($sformatf("t1 m_last T+%0d", k), bus.m_last, (k == 5));
            end
            check($sformatf("t1 done T+%0d", k), done, (k == 6));
        end
        check("t1 beats_sent", beats_sent, 4);
        check("t1 err", err, 0);

        // Zero-length burst finishes the cycle after start.
        flush_fifo();
        push_word(8'hAA);
        @(posedge clk); #1;
        start = 1'b1;
        burst_len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("t3 done T+1", done, 1);
        check("t3 rd_en", bus.fifo_rd_en, 0);
        check("t3 m_valid", bus.m_valid, 0);
        @(negedge clk);
        check("t3 done T+2", done, 0);
        check("t3 m_valid T+2", bus.m_valid, 0);
        check("t3 beats_sent", beats_sent, 0);

        // Vector table: {len, avail, ready_mode, beats, err, mid-burst start}.
        vecs[0] = '{4, 4, 0, 4, 0, 0};
        vecs[1] = '{6, 6, 1, 6, 0, 0};
        vecs[2] = '{0, 3, 0, 0, 0, 0};
        vecs[3] = '{5, 2, 2, 2, 1, 0};
        vecs[4] = '{1, 1, 2, 1, 0, 0};
        vecs[5] = '{300, 300, 0, 256, 0, 1};
        vecs[6] = '{7, 10, 1, 7, 0, 0};
        for (int v = 0; v < 7; v++) begin
            run_burst(vecs[v].len, vecs[v].avail, vecs[v].mode, vecs[v].exp_beats,
                      vecs[v].exp_err, vecs[v].mid_start, $sformatf("vec%0d", v));
        end

        // Reset while a beat is in flight and 3 words remain to pop.
        flush_fifo();
        for (int i = 0; i < 8; i++) push_word(8'h40 + DW'(i));
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        burst_len = LW'(8);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("t6 m_valid before reset", bus.m_valid, 1);
        rst_n = 1'b0;
        #1;
        check("t6 m_valid async", bus.m_valid, 0);
        check("t6 busy async", busy, 0);
        check("t6 rd_en async", bus.fifo_rd_en, 0);
        check("t6 beats_sent async", beats_sent, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("t6 fifo still holds words", bus.fifo_empty, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t6 idle rd_en", bus.fifo_rd_en, 0);
            check("t6 idle busy", busy, 0);
        end

        // Random bursts against the reference model.
        for (int r = 0; r < 12; r++) begin
            int len, avail, mode;
            len   = int'($urandom_range(0, 20));
            avail = int'($urandom_range(0, 24));
            mode  = int'($urandom_range(0, 2));
            run_burst(len, avail, mode, model_beats(len, avail), model_err(len, avail), 0,
                      $sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side companion for the team's synchronous show-ahead FIFO. On a start command it pops a programmed number of words from the FIFO and presents them on a registered valid/ready stream, flagging the final beat with m_last. It runs at one beat per cycle under no backpressure, tracks accepted beats, and aborts with an error flag if the FIFO stays empty too long mid-burst. It sits between the FIFO read port and any downstream stream consumer.

Parameters:
DATA_WIDTH, 8, FIFO word and stream data width
MAX_BURST, 256, largest burst length; larger requests are clamped to this value
LEN_WIDTH, $clog2(MAX_BURST+1), width of burst_len and beats_sent
TIMEOUT, 64, consecutive empty-FIFO cycles in RUN before abort; 0 disables the timeout
TO_WIDTH, $clog2(TIMEOUT+1), stall counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  burst request; sampled only in IDLE
burst_len  in  LEN_WIDTH  beats to read; latched on an accepted start
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at burst end, whether normal or aborted
err  out  1  high if the last burst timed out; held until the next accepted start
beats_sent  out  LEN_WIDTH  count of beats accepted downstream in the current or last burst
fifo_empty  in  1  FIFO empty flag
fifo_dout  in  DATA_WIDTH  FIFO head word; combinational and valid whenever !fifo_empty
fifo_rd_en  out  1  pop strobe; the FIFO advances on the clock edge
m_valid  out  1  stream valid
m_ready  in  1  stream ready
m_data  out  DATA_WIDTH  stream data
m_last  out  1  marks the final beat of a burst

Behaviour:
- Reset: state = IDLE. busy, done, err, fifo_rd_en, m_valid and m_last are 0. m_data, beats_sent, remaining counter and stall counter are 0.
- States are IDLE, RUN, FLUSH and DONE. State is registered. busy is decoded from state.
- IDLE, start=1:
  - Latch len = min(burst_len, MAX_BURST) into remaining.
  - Clear beats_sent, err and the stall counter.
  - If len == 0, go to DONE; otherwise go to RUN.
- start is ignored in every state other than IDLE.
- Output slot free: slot_free = !m_valid || m_ready.
- Pop rule (combinational): fifo_rd_en = (state == RUN) && remaining != 0 && !fifo_empty && slot_free.
  - fifo_rd_en is never asserted while fifo_empty = 1.
- On a pop edge:
  - m_data <= fifo_dout, m_valid <= 1, m_last <= (remaining == 1).
  - remaining decrements and the stall counter clears.
- With no pop and m_ready = 1: m_valid <= 0 and m_last <= 0.
- While m_valid && !m_ready, m_data and m_last hold stable.
- beats_sent increments on every m_valid && m_ready.
- Latency: the first pop happens at the earliest in the cycle after start, so m_valid rises 2 cycles after start. Sustained throughput is 1 beat/cycle.
- RUN transitions:
  - Pop with remaining == 1: go to FLUSH.
  - TIMEOUT != 0 and fifo_empty: the stall counter increments each cycle and saturates at TIMEOUT.
  - Stall counter == TIMEOUT: set err <= 1 and go to FLUSH. No m_last is emitted; downstream sees a truncated packet flagged by err.
- FLUSH: move to DONE once slot_free (the output register has drained or is being accepted this cycle). No pops occur in FLUSH.
- DONE: done = 1 for exactly one cycle, then IDLE. err and beats_sent hold.
- Reset mid-burst: all state and outputs clear immediately. Any in-flight beat is dropped and there is no pop until a new start.

Test Plan:
1. Normal burst: FIFO preloaded 0x10..0x13, burst_len=4, m_ready=1, start at cycle T.
   -> fifo_rd_en high T+1..T+4.
   -> m_valid high T+2..T+5 carrying 0x10, 0x11, 0x12, 0x13; m_last only with 0x13.
   -> done=1 at T+6; beats_sent=4; err=0.
2. Backpressure: burst_len=6 with 6 words queued, m_ready pattern 1,0,1,0,...
   -> all 6 words delivered in order, no duplicates.
   -> m_data held stable while not ready; fifo_rd_en only when slot_free; beats_sent=6.
3. Zero length: burst_len=0, start at T -> done=1 at T+1; fifo_rd_en and m_valid never assert; beats_sent=0.
4. Timeout: TIMEOUT=8, burst_len=5, only 2 words in FIFO.
   -> 2 beats delivered with m_last=0.
   -> err=1, done pulse, beats_sent=2, busy low afterwards.
   -> A following start clears err.
5. Clamp and ignore: burst_len=300 -> exactly 256 beats, m_last on beat 256. A start pulse mid-burst changes nothing.
6. Reset mid-burst: drop rst_n while m_valid=1 with 3 beats remaining.
   -> m_valid, busy and fifo_rd_en go to 0 asynchronously.
   -> After release the block stays idle and does not pop until the next start.
